// File: rtl/mux_bus_arbiter_pkg.sv
// Shared encodings for the two-requester bus arbiter.
// Holds the state, owner and bus-width definitions.
package arb_defs;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  typedef enum logic {
    OWNER0 = 1'b0,
    OWNER1 = 1'b1
  } owner_t;

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Requester, grant and sink handshake bundle for mux_bus_arbiter.
// arb is the arbiter side; master is the requester/sink side.
interface mux_bus_arbiter_if;
  import arb_defs::*;

  logic             req0;
  logic             req1;
  logic [BUS_W-1:0] data0;
  logic [BUS_W-1:0] data1;
  logic             grant0;
  logic             grant1;
  logic             ack0;
  logic             ack1;
  logic             mux_sel;
  logic [BUS_W-1:0] bus_data;
  logic             bus_valid;
  logic             bus_ready;

  modport arb (
    input  req0, req1, data0, data1,
    input  bus_ready,
    output grant0, grant1, ack0, ack1,
    output mux_sel, bus_data, bus_valid
  );

  modport master (
    output req0, req1, data0, data1,
    output bus_ready,
    input  grant0, grant1, ack0, ack1,
    input  mux_sel, bus_data, bus_valid
  );

endinterface

// File: rtl/mux_bus_arbiter_mux2to1.sv
// Plain 2:1 data mux used on the arbiter write-back path.
// Mux_sel = 0 picks input1, 1 picks input2.
module Mux2To1 #(
  parameter int W = 8
) (
  input  logic         Mux_sel,
  input  logic [W-1:0] input1,
  input  logic [W-1:0] input2,
  output logic [W-1:0] mux_out
);

  assign mux_out = Mux_sel ? input2 : input1;

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin two-requester bus arbiter with burst limit.
// ARB_STATS_EN adds saturating per-requester beat counters.
module mux_bus_arbiter
  import arb_defs::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux_bus_arbiter_if.arb bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   beats0,
  output logic [15:0]   beats1
`endif
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MAX_BURST - 1);

  state_t           state, state_n;
  owner_t           last_owner, owner_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sel_q, sel_n;
  logic             g0, g1, valid, beat;

  assign g0    = (state == GRANT0);
  assign g1    = (state == GRANT1);
  // Reset masks the handshake so an aborted burst acks nothing.
  assign valid = ~reset &
    ((g0 & bus.req0) | (g1 & bus.req1));
  assign beat  = valid & bus.bus_ready;

  assign bus.grant0    = g0;
  assign bus.grant1    = g1;
  assign bus.bus_valid = valid;
  assign bus.ack0      = beat & g0;
  assign bus.ack1      = beat & g1;
  assign bus.mux_sel   = sel_q;

  Mux2To1 #(.W(BUS_W)) u_mux (
    .Mux_sel (sel_q),
    .input1  (bus.data0),
    .input2  (bus.data1),
    .mux_out (bus.bus_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER1;
      cnt        <= '0;
      sel_q      <= 1'b0;
    end else begin
      state      <= state_n;
      last_owner <= owner_n;
      cnt        <= cnt_n;
      sel_q      <= sel_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = last_owner;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req0 && bus.req1)
          state_n = (last_owner == OWNER1) ?
            GRANT0 : GRANT1;
        else if (bus.req0)
          state_n = GRANT0;
        else if (bus.req1)
          state_n = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0 || (beat && cnt == LAST)) begin
          owner_n = OWNER0;
          cnt_n   = '0;
          if (bus.req1)      state_n = GRANT1;
          else if (bus.req0) state_n = GRANT0;
          else               state_n = IDLE;
        end else if (beat) begin
          cnt_n = cnt + 1'b1;
        end
      end
      GRANT1: begin
        if (!bus.req1 || (beat && cnt == LAST)) begin
          owner_n = OWNER1;
          cnt_n   = '0;
          if (bus.req0)      state_n = GRANT0;
          else if (bus.req1) state_n = GRANT1;
          else               state_n = IDLE;
        end else if (beat) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    sel_n = sel_q;
    unique case (state_n)
      GRANT0:  sel_n = 1'b0;
      GRANT1:  sel_n = 1'b1;
      default: sel_n = sel_q;
    endcase
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beats0 <= '0;
      beats1 <= '0;
    end else begin
      if (bus.ack0 && beats0 != 16'hFFFF)
        beats0 <= beats0 + 16'd1;
      if (bus.ack1 && beats1 != 16'hFFFF)
        beats1 <= beats1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed self-checking bench for mux_bus_arbiter.
// Define ARB_STATS_EN to also exercise the beat counters.
module tb_mux_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  mux_bus_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [15:0] beats0, beats1;
`endif

  mux_bus_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .beats0 (beats0),
    .beats1 (beats1)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = 8'h00;
    bus.data1 = 8'h00;
    bus.bus_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus.grant0, bus.grant1} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_grant got=%b want=00",
        {bus.grant0, bus.grant1});
    end
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.mux_sel, bus.bus_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=0000",
        {bus.ack0, bus.ack1, bus.mux_sel, bus.bus_valid});
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req0 = 1'b1;
    bus.data0 = 8'h11;
    bus.bus_ready = 1'b1;
    step();
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel} !== 3'b100) begin
      n_bad++;
      $display("FAIL single_grant got=%b want=100",
        {bus.grant0, bus.grant1, bus.mux_sel});
    end
    n_vec++;
    if (bus.bus_data !== 8'h11) begin
      n_bad++;
      $display("FAIL single_data got=%h want=11", bus.bus_data);
    end
    n_vec++;
    if ({bus.bus_valid, bus.ack0, bus.ack1} !== 3'b110) begin
      n_bad++;
      $display("FAIL single_hs got=%b want=110",
        {bus.bus_valid, bus.ack0, bus.ack1});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = 8'hA0;
    bus.data1 = 8'hB1;
    bus.bus_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.grant0, bus.grant1, bus.ack0} !== 3'b101) begin
        n_bad++;
        $display("FAIL rr_g0_beat%0d got=%b want=101", i,
          {bus.grant0, bus.grant1, bus.ack0});
      end
      step();
    end
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel, bus.ack1} !== 4'b0111) begin
      n_bad++;
      $display("FAIL rr_handoff1 got=%b want=0111",
        {bus.grant0, bus.grant1, bus.mux_sel, bus.ack1});
    end
    n_vec++;
    if (bus.bus_data !== 8'hB1) begin
      n_bad++;
      $display("FAIL rr_data1 got=%h want=b1", bus.bus_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.grant1, bus.ack1} !== 2'b11) begin
        n_bad++;
        $display("FAIL rr_g1_beat%0d got=%b want=11", i,
          {bus.grant1, bus.ack1});
      end
      step();
    end
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel} !== 3'b100) begin
      n_bad++;
      $display("FAIL rr_handoff0 got=%b want=100",
        {bus.grant0, bus.grant1, bus.mux_sel});
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.req1 = 1'b1;
    bus.data1 = 8'h5C;
    step();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus.grant1, bus.bus_valid, bus.ack1} !== 3'b110) begin
        n_bad++;
        $display("FAIL stall_cyc%0d got=%b want=110", i,
          {bus.grant1, bus.bus_valid, bus.ack1});
      end
      step();
    end
    bus.bus_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.ack1 !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release_ack got=%b want=1", bus.ack1);
    end
    // Rival request must wait for the 4-beat limit if stalls were not counted.
    bus.req0 = 1'b1;
    step();
    step();
    step();
    n_vec++;
    if ({bus.grant1, bus.ack1} !== 2'b11) begin
      n_bad++;
      $display("FAIL stall_beat4 got=%b want=11",
        {bus.grant1, bus.ack1});
    end
    step();
    n_vec++;
    if ({bus.grant0, bus.grant1} !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_handoff got=%b want=10",
        {bus.grant0, bus.grant1});
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.req0 = 1'b1;
    bus.data0 = 8'h33;
    bus.bus_ready = 1'b1;
    step();
    step();
    n_vec++;
    if ({bus.grant0, bus.ack0} !== 2'b11) begin
      n_bad++;
      $display("FAIL drop_beat2 got=%b want=11",
        {bus.grant0, bus.ack0});
    end
    bus.req0 = 1'b0;
    step();
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL drop_idle0 got=%b want=0000",
        {bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid});
    end
    bus.req1 = 1'b1;
    step();
    bus.req1 = 1'b0;
    step();
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid} !== 4'b0010) begin
      n_bad++;
      $display("FAIL drop_idle1_hold got=%b want=0010",
        {bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req1 = 1'b1;
    bus.data1 = 8'h77;
    bus.bus_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_ack got=%b want=00",
        {bus.ack0, bus.ack1});
    end
    step();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid, bus.ack1} !== 5'b00000) begin
      n_bad++;
      $display("FAIL rstmid_outs got=%b want=00000",
        {bus.grant0, bus.grant1, bus.mux_sel, bus.bus_valid, bus.ack1});
    end
    bus.req0 = 1'b1;
    step();
    n_vec++;
    if ({bus.grant0, bus.grant1} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_tie got=%b want=10",
        {bus.grant0, bus.grant1});
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req1 = 1'b1;
    bus.bus_ready = 1'b1;
    step();
    repeat (5) step();
    bus.req1 = 1'b0;
    #1;
    n_vec++;
    if (beats1 !== 16'd5) begin
      n_bad++;
      $display("FAIL stats_beats1 got=%0d want=5", beats1);
    end
    n_vec++;
    if (beats0 !== 16'd0) begin
      n_bad++;
      $display("FAIL stats_beats0 got=%0d want=0", beats0);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
